// File: rtl/shift_left_sequential.sv
// Sequential left shifter: one bit per SHIFT cycle, result published with a one-cycle DONE pulse.
// Optional macro SHL_FAST_STEP_EN adds 4-bit strides while the remaining count is at least 4.
module shift_left_sequential #(
  parameter int WIDTH = 32,
  parameter int SW    = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] IN,
  input  logic [SW-1:0]    SHAMT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SW-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, FIN: begin
        // FIN accepts a new request so operations can run back to back.
        if (START) begin
          work_d  = IN;
          cnt_d   = SHAMT;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          out_d   = work_q;
          state_d = FIN;
        end else begin
`ifdef SHL_FAST_STEP_EN
          if (int'(cnt_q) >= 4) begin
            work_d = {work_q[WIDTH-5:0], 4'b0000};
            cnt_d  = cnt_q - SW'(4);
          end else begin
            work_d = {work_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q - SW'(1);
          end
`else
          work_d = {work_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q - SW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY = (state_q == SHIFT);
  assign DONE = (state_q == FIN);
  assign OUT  = out_q;

endmodule

// File: tb/tb_shift_left_sequential.sv
// Directed and random bench for shift_left_sequential; latency expectation follows SHL_FAST_STEP_EN.
module tb_shift_left_sequential;

  logic        clk = 1'b0;
  logic        rst_r = 1'b0;
  logic        start_r = 1'b0;
  logic [31:0] in_r = '0;
  logic [4:0]  shamt_r = '0;
  logic        busy_w, done_w;
  logic [31:0] out_w;

  int n_vec = 0;
  int n_err = 0;

  shift_left_sequential #(.WIDTH(32), .SW(5)) dut (
    .CLK(clk), .RST(rst_r), .START(start_r), .IN(in_r), .SHAMT(shamt_r),
    .BUSY(busy_w), .DONE(done_w), .OUT(out_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Edges from the accepting edge (counted as 1) to the first DONE cycle.
  function automatic int exp_lat(input int s);
`ifdef SHL_FAST_STEP_EN
    return s / 4 + s % 4 + 2;
`else
    return s + 2;
`endif
  endfunction

  // Wait for DONE after the accepting edge; returns edges counted from that edge.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!done_w && edges < 80) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // Caller guarantees the DUT is IDLE or FIN and inputs are driven away from the edge.
  task automatic run_op(input string tag, input logic [31:0] a, input int s,
                        input logic [31:0] exp_out);
    int edges;
    in_r = a; shamt_r = 5'(s); start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    in_r = ~a; shamt_r = ~5'(s);
    check({tag, "_busy"}, 64'(busy_w), 64'd1);
    wait_done(edges);
    check({tag, "_lat"}, 64'(edges), 64'(exp_lat(s)));
    check({tag, "_out"}, 64'(out_w), 64'(exp_out));
  endtask

  initial begin
    int edges;
    int done_seen;
    logic [31:0] a;
    int s;

    #1 rst_r = 1'b1;
    #2;
    check("rst_out", 64'(out_w), 64'd0);
    check("rst_busy", 64'(busy_w), 64'd0);
    check("rst_done", 64'(done_w), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_r = 1'b0;
    @(posedge clk); #1;

    run_op("shamt0", 32'h0000_0001, 0, 32'h0000_0001);
    @(posedge clk); #1;
    check("done_pulse", 64'(done_w), 64'd0);
    check("out_hold", 64'(out_w), 64'h0000_0001);
    run_op("shamt31", 32'h8000_0001, 31, 32'h8000_0000);
    @(posedge clk); #1;

    // Abort mid-shift: asynchronous clear, no DONE afterwards.
    in_r = 32'hFFFF_FFFF; shamt_r = 5'd20; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_r = 1'b1;
    #1;
    check("abort_out", 64'(out_w), 64'd0);
    check("abort_busy", 64'(busy_w), 64'd0);
    check("abort_done", 64'(done_w), 64'd0);
    @(posedge clk); #1;
    rst_r = 1'b0;
    done_seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_w || busy_w) done_seen++;
    end
    check("abort_quiet", 64'(done_seen), 64'd0);
    run_op("after_rst", 32'h0000_0003, 2, 32'h0000_000C);
    @(posedge clk); #1;

    // Request while busy is dropped and not queued.
    in_r = 32'h1234_5678; shamt_r = 5'd4; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    @(posedge clk); #1;
    in_r = 32'hFFFF_FFFF; shamt_r = 5'd8; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    edges = 3;
    while (!done_w && edges < 80) begin
      @(posedge clk); #1;
      edges++;
    end
    check("ign_lat", 64'(edges), 64'(exp_lat(4)));
    check("ign_out", 64'(out_w), 64'h2345_6780);
    @(posedge clk); #1;
    check("ign_idle_busy", 64'(busy_w), 64'd0);
    check("ign_idle_done", 64'(done_w), 64'd0);

    // Back-to-back: START held through FIN.
    in_r = 32'h0000_000F; shamt_r = 5'd1; start_r = 1'b1;
    @(posedge clk); #1;
    wait_done(edges);
    check("b2b1_lat", 64'(edges), 64'(exp_lat(1)));
    check("b2b1_out", 64'(out_w), 64'h0000_001E);
    in_r = 32'h0000_000F; shamt_r = 5'd28;
    @(posedge clk); #1;
    start_r = 1'b0;
    check("b2b2_busy", 64'(busy_w), 64'd1);
    check("b2b2_hold", 64'(out_w), 64'h0000_001E);
    wait_done(edges);
    check("b2b2_lat", 64'(edges), 64'(exp_lat(28)));
    check("b2b2_out", 64'(out_w), 64'hF000_0000);
    @(posedge clk); #1;

    for (int i = 0; i < 2000; i++) begin
      a = $urandom;
      s = $urandom_range(31, 0);
      run_op("rand", a, s, a << s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
